// File: rtl/reg_wb_queue.sv
// Write-back queue between the execute/memory stages and the register file write port.
// Buffers (dest, value) pairs, drains one per cycle, and forwards queued values to readers.
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_sel,
  input  logic [DW-1:0]            in_data,
  input  logic                     wr_stall,
  output logic                     RegWrite,
  output logic [AW-1:0]            sel,
  output logic [DW-1:0]            data,
  input  logic [AW-1:0]            selA,
  input  logic [AW-1:0]            selB,
  output logic                     fwdA_hit,
  output logic [DW-1:0]            fwdA_data,
  output logic                     fwdB_hit,
  output logic [DW-1:0]            fwdB_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] q_sel  [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          push;
  logic          pop;
  logic          not_empty;
  logic [PW-1:0] idx;

  assign not_empty = (count != '0);
  assign in_ready  = (count != CW'(DEPTH));
  // Writes to r0 complete the handshake but never occupy a slot.
  assign push      = in_valid && in_ready && (in_sel != '0);
  assign pop       = not_empty && !wr_stall;

  assign RegWrite  = pop;
  assign sel       = not_empty ? q_sel[rp]  : '0;
  assign data      = not_empty ? q_data[rp] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; it is only observed through valid slots.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      q_sel[wp]  <= in_sel;
      q_data[wp] <= in_data;
    end
  end

  // Walk oldest to youngest so the last match (closest to wp) wins.
  always_comb begin
    fwdA_hit  = 1'b0;
    fwdA_data = '0;
    fwdB_hit  = 1'b0;
    fwdB_data = '0;
    idx       = rp;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rp + PW'(i);
      if (CW'(i) < count) begin
        if ((selA != '0) && (q_sel[idx] == selA)) begin
          fwdA_hit  = 1'b1;
          fwdA_data = q_data[idx];
        end
        if ((selB != '0) && (q_sel[idx] == selB)) begin
          fwdB_hit  = 1'b1;
          fwdB_data = q_data[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: reset, single write, full queue, r0 discard,
// forwarding priority, sustained throughput and reset while stalled.
module tb_reg_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_sel;
  logic [DW-1:0] in_data;
  logic          wr_stall;
  logic          RegWrite;
  logic [AW-1:0] sel;
  logic [DW-1:0] data;
  logic [AW-1:0] selA;
  logic [AW-1:0] selB;
  logic          fwdA_hit;
  logic [DW-1:0] fwdA_data;
  logic          fwdB_hit;
  logic [DW-1:0] fwdB_data;
  logic [CW-1:0] count;

  int tests_run    = 0;
  int tests_failed = 0;

  reg_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .wr_stall(wr_stall), .RegWrite(RegWrite), .sel(sel), .data(data),
    .selA(selA), .selB(selB),
    .fwdA_hit(fwdA_hit), .fwdA_data(fwdA_data),
    .fwdB_hit(fwdB_hit), .fwdB_data(fwdB_data),
    .count(count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0;
    wr_stall = 1'b0; selA = 5'd3; selB = 5'd4;
    tick(); tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if (RegWrite !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_regwrite: got %b expected 0", RegWrite); end
    tests_run++;
    if (sel !== '0 || data !== '0) begin tests_failed++; $display("[TB] FAIL reset_seldata: got %0d/%h expected 0/0", sel, data); end
    tests_run++;
    if (fwdA_hit !== 1'b0 || fwdB_hit !== 1'b0 || fwdA_data !== '0 || fwdB_data !== '0) begin
      tests_failed++; $display("[TB] FAIL reset_fwd: got %b%b %h %h expected 00 0 0", fwdA_hit, fwdB_hit, fwdA_data, fwdB_data);
    end
    tests_run++;
    if (count !== '0 || in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_count: got count=%0d ready=%b expected 0/1", count, in_ready); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_sel = 5'd3; in_data = 32'hDEADBEEF; wr_stall = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (RegWrite !== 1'b1 || sel !== 5'd3 || data !== 32'hDEADBEEF) begin
      tests_failed++; $display("[TB] FAIL single_write: got %b %0d %h expected 1 3 deadbeef", RegWrite, sel, data);
    end
    tick();
    tests_run++;
    if (count !== '0 || RegWrite !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_drained: got count=%0d wr=%b expected 0/0", count, RegWrite); end
  endtask

  task automatic test_full();
    wr_stall = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      in_valid = 1'b1; in_sel = AW'(i); in_data = 32'h11 * i;
      tick();
    end
    tests_run++;
    if (count !== CW'(DEPTH) || in_ready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL full_state: got count=%0d ready=%b expected %0d/0", count, in_ready, DEPTH);
    end
    in_sel = 5'd9; in_data = 32'h99;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (count !== CW'(DEPTH) || RegWrite !== 1'b0 || sel !== 5'd1) begin
      tests_failed++; $display("[TB] FAIL full_reject: got count=%0d wr=%b sel=%0d expected %0d/0/1", count, RegWrite, sel, DEPTH);
    end
    wr_stall = 1'b0;
    #1;
    for (int i = 1; i <= DEPTH; i++) begin
      tests_run++;
      if (RegWrite !== 1'b1 || sel !== AW'(i) || data !== 32'h11 * i) begin
        tests_failed++; $display("[TB] FAIL full_drain%0d: got %b %0d %h expected 1 %0d %h", i, RegWrite, sel, data, i, 32'h11 * i);
      end
      tick();
    end
    tests_run++;
    if (count !== '0 || RegWrite !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_empty: got count=%0d wr=%b expected 0/0", count, RegWrite); end
  endtask

  task automatic test_zero_reg();
    in_valid = 1'b1; in_sel = 5'd0; in_data = 32'hFFFFFFFF; selA = 5'd0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL zero_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (count !== '0 || RegWrite !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_discard: got count=%0d wr=%b expected 0/0", count, RegWrite); end
    tests_run++;
    if (fwdA_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_fwd: got %b expected 0", fwdA_hit); end
    tick();
    tests_run++;
    if (RegWrite !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_late: got %b expected 0", RegWrite); end
  endtask

  task automatic test_forward();
    logic [AW-1:0] fs [3];
    logic [DW-1:0] fd [3];
    fs[0] = 5'd5; fd[0] = 32'hA;
    fs[1] = 5'd5; fd[1] = 32'hB;
    fs[2] = 5'd7; fd[2] = 32'hC;
    wr_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sel = fs[i]; in_data = fd[i];
      tick();
    end
    in_valid = 1'b0; selA = 5'd5; selB = 5'd7;
    #1;
    tests_run++;
    if (fwdA_hit !== 1'b1 || fwdA_data !== 32'hB) begin tests_failed++; $display("[TB] FAIL fwd_youngest: got %b %h expected 1 b", fwdA_hit, fwdA_data); end
    tests_run++;
    if (fwdB_hit !== 1'b1 || fwdB_data !== 32'hC) begin tests_failed++; $display("[TB] FAIL fwd_b: got %b %h expected 1 c", fwdB_hit, fwdB_data); end
    selB = 5'd6;
    #1;
    tests_run++;
    if (fwdB_hit !== 1'b0 || fwdB_data !== '0) begin tests_failed++; $display("[TB] FAIL fwd_miss: got %b %h expected 0 0", fwdB_hit, fwdB_data); end
    // in_* does not forward in the same cycle.
    selB = 5'd12; in_valid = 1'b1; in_sel = 5'd12; in_data = 32'h77;
    #1;
    tests_run++;
    if (fwdB_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL fwd_no_bypass: got %b expected 0", fwdB_hit); end
    in_valid = 1'b0; selB = 5'd7; wr_stall = 1'b0;
    tick(); tick();
    tests_run++;
    if (RegWrite !== 1'b1 || sel !== 5'd7 || fwdB_hit !== 1'b1 || fwdB_data !== 32'hC || fwdA_hit !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL fwd_head: got wr=%b sel=%0d b=%b/%h a=%b expected 1 7 1/c 0", RegWrite, sel, fwdB_hit, fwdB_data, fwdA_hit);
    end
    tick();
    tests_run++;
    if (fwdB_hit !== 1'b0 || count !== '0) begin tests_failed++; $display("[TB] FAIL fwd_after_pop: got %b count=%0d expected 0/0", fwdB_hit, count); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] es;
    logic [DW-1:0] ed;
    wr_stall = 1'b0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      es = AW'((i % 31) + 1);
      ed = 32'h1000 + 32'(i) * 32'h101;
      in_valid = 1'b1; in_sel = es; in_data = ed;
      tick();
      tests_run++;
      if (count !== CW'(1) || RegWrite !== 1'b1 || sel !== es || data !== ed) begin
        tests_failed++; $display("[TB] FAIL b2b_%0d: got count=%0d wr=%b %0d %h expected 1 1 %0d %h", i, count, RegWrite, sel, data, es, ed);
      end
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (count !== '0) begin tests_failed++; $display("[TB] FAIL b2b_empty: got %0d expected 0", count); end
  endtask

  task automatic test_reset_stalled();
    int writes;
    wr_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sel = AW'(20 + i); in_data = 32'h500 + 32'(i);
      tick();
    end
    tests_run++;
    if (count !== CW'(3)) begin tests_failed++; $display("[TB] FAIL rst_prefill: got %0d expected 3", count); end
    in_sel = 5'd8; in_data = 32'h88;
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (count !== '0 || RegWrite !== 1'b0 || sel !== '0) begin
      tests_failed++; $display("[TB] FAIL rst_cleared: got count=%0d wr=%b sel=%0d expected 0/0/0", count, RegWrite, sel);
    end
    wr_stall = 1'b0;
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (RegWrite === 1'b1) writes++;
      tick();
    end
    tests_run++;
    if (writes != 0) begin tests_failed++; $display("[TB] FAIL rst_no_write: got %0d writes expected 0", writes); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_zero_reg();
    test_forward();
    test_back_to_back();
    test_reset_stalled();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_wb_queue.md
# reg_wb_queue

Write-back queue that serialises results from the execute/memory stages onto the single write port of the 32×32-bit register file (`sel`, `RegWrite`, `data`). It buffers up to `DEPTH` pending (destination, value) pairs and drains one per cycle when the register file is not stalled. It provides age-ordered forwarding of queued-but-unwritten values to the two read selectors `selA`/`selB`, so readers never see stale register contents.

## Interface
Parameters:
- `DEPTH`, 4, queue entries; must be a power of two and ≥ 2
- `AW`, 5, register address width
- `DW`, 32, data width

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  producer offers a result this cycle
- `in_ready`  out  1  queue can accept; equals `count != DEPTH`
- `in_sel`  in  AW  destination register of offered result
- `in_data`  in  DW  value of offered result
- `wr_stall`  in  1  register-file write port unavailable; holds the head entry
- `RegWrite`  out  1  write strobe to register file
- `sel`  out  AW  write address to register file
- `data`  out  DW  write data to register file
- `selA`  in  AW  read selector A (same value given to the register file)
- `selB`  in  AW  read selector B
- `fwdA_hit`  out  1  queued entry matches `selA`
- `fwdA_data`  out  DW  youngest matching queued value for `selA`
- `fwdB_hit`  out  1  queued entry matches `selB`
- `fwdB_data`  out  DW  youngest matching queued value for `selB`
- `count`  out  log2(DEPTH)+1  number of valid entries

## Operation
- Storage: circular buffer of `DEPTH` entries {sel, data}, write pointer `wp`, read pointer `rp`, occupancy `count`; pointers wrap modulo `DEPTH`.
- Push: `in_valid && in_ready && in_sel != 0` stores {in_sel, in_data} at `wp`, then `wp` increments.
- Zero register: `in_valid && in_ready && in_sel == 0` completes the handshake, but the result is discarded. No entry is created and `count` is unchanged.
- Drain: `RegWrite = (count != 0) && !wr_stall`. `sel`/`data` show the head entry at `rp` whenever `count != 0`, and 0 when empty. On an edge with `RegWrite == 1`, `rp` increments.
- Simultaneous push and pop: `count` is unchanged, and both pointers advance.
- Full: `in_ready = 0`. A pop in the same cycle does not open a slot for that cycle; the slot becomes available in the next cycle.
- Forwarding: `fwdX_hit = (selX != 0) && any valid entry has sel == selX`. `fwdX_data` is the data of the youngest matching entry, i.e. the one closest to `wp`; it is 0 when there is no hit.
- Forwarding ignores the same-cycle `in_*` input.
- The head entry being written this cycle is still forwarded; it is no longer visible after the pop edge.
- Multiple entries may target the same register. They drain in order, so the register file ends with the youngest value.
- Reset: on a `reset` edge, `count`, `wp` and `rp` become 0 and all queued contents are dropped, including a head mid-drain. While `reset` is high, `in_ready` still follows `count`; any push in that cycle is lost.

## Timing
- Reset values: `RegWrite = 0`, `sel = 0`, `data = 0`, `fwdA_hit = fwdB_hit = 0`, `fwdA_data = fwdB_data = 0`, `count = 0`, `in_ready = 1`.
- All outputs are combinational from registered state plus `wr_stall`/`selA`/`selB`. There is no input-to-output path from `in_*`.
- Latency: a result accepted at edge N appears as the head in cycle N+1 if the queue was empty. It is written at edge N+1 if `wr_stall = 0`.
- Throughput: one push and one pop per cycle sustained.
- `wr_stall` held high: the head and `sel`/`data` stay stable and `RegWrite` stays 0.

## Test plan
- Reset, then push {3, 0xDEADBEEF} with no stall → next cycle `RegWrite = 1`, `sel = 3`, `data = 0xDEADBEEF`; cycle after that `count = 0`, `RegWrite = 0`.
- With `wr_stall = 1`, push {1,0x11}, {2,0x22}, {3,0x33}, {4,0x44} → `count = 4`, `in_ready = 0`, fifth push not accepted. Release stall → writes 1, 2, 3, 4 in order on consecutive cycles.
- Push {0, 0xFFFFFFFF} → handshake completes, `count` stays 0, `RegWrite` never asserts. With `selA = 0`, `fwdA_hit = 0`.
- With stall high, push {5,0xA}, then {5,0xB}, then {7,0xC}; set `selA = 5`, `selB = 7` → `fwdA_hit = 1` with `fwdA_data = 0xB`, and `fwdB_hit = 1` with `fwdB_data = 0xC`.
- Continuous push and drain for 3×`DEPTH` cycles → `count` steady at 1 and write order equals push order across pointer wrap.
- Stall high with 3 entries queued, then assert `reset` for one cycle → next cycle `count = 0`, `RegWrite = 0`, no write issued after stall release.
